// File: rtl/mux16b2_sel.sv
`timescale 1ns/1ps
// mux16b2_sel: 2:1 word select for datapath select points, with a registered copy of the result.
// Latency: r is combinational (zero cycles); r_q follows the inputs by one core clock.
// Backpressure: none. There is no handshake and no enable, and r_q captures on every rising clk.
//
// Ports:
//   clk  - clock; r_q updates on the rising edge
//   rst  - asynchronous active-high reset; clears r_q only
//   s    - select: 0 chooses a, 1 chooses b
//   a, b - data inputs, WIDTH bits each
//   r    - combinational select result; independent of clk and rst
//   r_q  - registered select result
module mux16b2_sel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_q
);

  logic [WIDTH-1:0] sel_dat;

  // A continuous assign keeps r purely combinational, so no latch can form.
  // The register samples this same net, so r and r_q never disagree about the select.
  assign sel_dat = s ? b : a;
  assign r       = sel_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= sel_dat;
    end
  end

endmodule

// File: tb/tb_mux16b2_sel.sv
`timescale 1ns/1ps
module tb_mux16b2_sel;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_q;

  int n_checks;
  int n_fail;

  mux16b2_sel #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .a   (a),
    .b   (b),
    .r   (r),
    .r_q (r_q)
  );

  // 10 ns period. Rising edges fall at 5, 15, 25 ns and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_r;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Adjacent rows differ only in s, so each odd row is a toggle of s within 1 ns.
    vecs[0] = '{1'b0, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{1'b0, 16'hA5A5, 16'h5A5A, 16'hA5A5};
    vecs[5] = '{1'b1, 16'hA5A5, 16'h5A5A, 16'h5A5A};
    vecs[6] = '{1'b0, 16'h8001, 16'h7FFE, 16'h8001};
    vecs[7] = '{1'b1, 16'h8001, 16'h7FFE, 16'h7FFE};

    // Reset state. r follows its inputs while rst is held high.
    rst = 1'b1;
    s   = 1'b0;
    a   = '0;
    b   = '0;
    #1;
    check("reset_r_q", r_q, 16'h0000);
    check("reset_r", r, 16'h0000);
    s = 1'b1;
    b = 16'hBEEF;
    #1;
    check("r_during_reset", r, 16'hBEEF);

    // Release rst on a rising edge. r_q must stay 0 for that edge and load on the next one.
    @(posedge clk);
    rst <= 1'b0;
    #1;
    check("release_edge_hold", r_q, 16'h0000);
    @(posedge clk);
    #1;
    check("release_next_load", r_q, 16'hBEEF);

    // Directed extremes and patterns.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s = vecs[i].s;
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_r", i), r, vecs[i].exp_r);
    end

    // Sweep a with s=0.
    s = 1'b0;
    b = '0;
    for (int i = 0; i < 256; i++) begin
      a = 16'(i);
      #1;
      check($sformatf("sweep_a_%0d", i), r, 16'(i));
    end

    // Sweep b with s=1. Changing a alone must leave r unchanged.
    s = 1'b1;
    a = 16'h3C3C;
    for (int i = 0; i < 16; i++) begin
      b = 16'(i);
      #1;
      check($sformatf("sweep_b_%0d", i), r, 16'(i));
      a = ~a;
      #1;
      check($sformatf("sweep_b_%0d_a_chg", i), r, 16'(i));
    end

    // Registered path. A mid-cycle change must not reach r_q before the next edge.
    @(negedge clk);
    s = 1'b1;
    b = 16'h1234;
    @(posedge clk);
    #1;
    check("reg_load_1234", r_q, 16'h1234);
    b = 16'h5678;
    #1;
    check("reg_hold_mid_cycle", r_q, 16'h1234);
    check("r_mid_cycle", r, 16'h5678);
    @(posedge clk);
    #1;
    check("reg_load_5678", r_q, 16'h5678);

    // Asynchronous reset asserted between edges.
    @(negedge clk);
    s = 1'b0;
    a = 16'hA5A5;
    @(posedge clk);
    #1;
    check("reg_load_a5a5", r_q, 16'hA5A5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_clear", r_q, 16'h0000);
    a = 16'h1111;
    #1;
    check("r_follows_in_reset", r, 16'h1111);
    @(posedge clk);
    #1;
    check("reset_holds_over_edge", r_q, 16'h0000);

    // Release rst between edges. The first edge afterwards loads the current selection.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("released_before_edge", r_q, 16'h0000);
    @(posedge clk);
    #1;
    check("load_after_release", r_q, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16b2_sel.md
Name: mux16b2_sel

Overview:
- 16-bit, 2-input word multiplexer used on datapath select points of the memory-to-memory vector processor.
- Primary output r is purely combinational: r = a when s=0, r = b when s=1.
- Also provides a clocked copy r_q, captured every clock, for callers that need a registered select result.
- Clocking and reset affect only r_q; r never depends on clk or rst.

Parameters:
- WIDTH, 16, data width of a, b, r, r_q. All behaviour is defined for WIDTH=16; other values scale identically.

Ports:
- clk  input  1  system clock; r_q updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; clears r_q.
- s  input  1  select: 0 chooses a, 1 chooses b.
- a  input  WIDTH  data input 0.
- b  input  WIDTH  data input 1.
- r  output  WIDTH  combinational mux result.
- r_q  output  WIDTH  registered mux result.

Behaviour:
- r = (s == 1'b0) ? a : b, bit-for-bit, no arithmetic and no width change.
- r has zero-cycle latency. It settles within one simulation time step (well under 1 ns) of any change on s, a or b.
- r ignores clk and rst entirely. It must track its inputs while rst is high.
- No latch may be inferred on r.
- s of X/Z: r is don't-care. Benches drive s only with 0 or 1.
- r_q reset: rst high forces r_q = 0 immediately, asynchronously, without waiting for clk. r_q stays 0 for as long as rst is high.
- r_q normal operation: on each rising clk edge with rst low, r_q <= (s ? b : a), sampled at that edge.
- r_q latency is one cycle relative to the inputs.
- Reset mid-operation: asserting rst between edges clears r_q at once. After rst deasserts, the first rising edge loads the current selection.
- If rst deasserts coincident with a clk edge, r_q holds 0 for that edge and loads on the next edge.
- No internal state other than the r_q register. No handshake and no enable.
- Wrap-around: inputs are plain vectors with no overflow semantics. a=16'hFFFF passes through unchanged.

Test Plan:
- Select a sweep: rst=0, s=0, b=0, a stepping 0..255 with 1 ns settle per step -> r == a at every step, including a=0 and a=255.
- Select b sweep: s=1, a arbitrary, b stepping 0..15 -> r == b at every step; changing a alone never changes r.
- Extremes: s=0, a=16'hFFFF, b=16'h0000 -> r=16'hFFFF. Toggle s to 1 -> r=16'h0000 within 1 ns. Swap the values and repeat.
- Async reset: r_q loaded with 16'hA5A5, then assert rst between clock edges -> r_q=0 before the next edge. During reset, r continues to follow s/a/b.
- Registered path: rst=0, s=1, b=16'h1234; apply a rising edge -> r_q=16'h1234 after that edge. Change b to 16'h5678 mid-cycle -> r_q unchanged until the next edge, then 16'h5678.
- Reset release: deassert rst coincident with a clk edge -> r_q stays 0 for that edge and loads the selected input on the following edge.
